// File: rtl/timer_1us.sv
// Microsecond timeout timer: a prescaler divides clk_36MHz down to 1 us ticks,
// and a saturating tick counter raises the registered flag q after COUNT_US ticks.
module timer_1us #(
   parameter int COUNT_US    = 1000,
   parameter int CLKS_PER_US = 36
) (
   input  logic clk_36MHz,
   input  logic reset,
   input  logic en,
   output logic q
);

   localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int CNT_W = $clog2(COUNT_US + 1);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(COUNT_US);

   // Power-up values are zero so the flag is clean before the first reset.
   logic [PRE_W-1:0] pre_reg    = '0;
   logic [CNT_W-1:0] us_cnt_reg = '0;
   logic             q_reg      = 1'b0;

   logic [PRE_W-1:0] pre_next;
   logic [CNT_W-1:0] us_cnt_next;
   logic             q_next;

   always_comb begin
      pre_next    = pre_reg;
      us_cnt_next = us_cnt_reg;
      q_next      = q_reg;
      if (!en) begin
         pre_next    = '0;
         us_cnt_next = '0;
         q_next      = 1'b0;
      end else if (us_cnt_reg != CNT_MAX) begin
         // Once saturated everything holds, so q can never re-trigger or wrap.
         if (pre_reg == PRE_LAST) begin
            pre_next    = '0;
            us_cnt_next = us_cnt_reg + CNT_W'(1);
            q_next      = (us_cnt_reg == CNT_W'(COUNT_US - 1));
         end else begin
            pre_next = pre_reg + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge clk_36MHz) begin
      if (!reset) begin
         pre_reg    <= '0;
         us_cnt_reg <= '0;
         q_reg      <= 1'b0;
      end else begin
         pre_reg    <= pre_next;
         us_cnt_reg <= us_cnt_next;
         q_reg      <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: tb/tb_timer_1us.sv
// Bench for timer_1us: three instances (default, medium, tiny) checked against a
// model that just counts consecutive enabled, out-of-reset edges.
module tb_timer_1us;

   localparam int N_D = 36000;   // default: 1000 us * 36 clocks
   localparam int N_M = 20 * 7;
   localparam int N_S = 2 * 3;

   logic clk_36MHz = 1'b0;
   always #5 clk_36MHz = ~clk_36MHz;

   logic reset = 1'b0;
   logic en_d = 1'b0, en_m = 1'b0, en_s = 1'b0;
   logic q_d, q_m, q_s;

   int k_d = 0, k_m = 0, k_s = 0;
   int tests_run = 0, tests_failed = 0;

   timer_1us dut_d (.clk_36MHz(clk_36MHz), .reset(reset), .en(en_d), .q(q_d));

   timer_1us #(.COUNT_US(20), .CLKS_PER_US(7)) dut_m (
      .clk_36MHz(clk_36MHz), .reset(reset), .en(en_m), .q(q_m));

   timer_1us #(.COUNT_US(2), .CLKS_PER_US(3)) dut_s (
      .clk_36MHz(clk_36MHz), .reset(reset), .en(en_s), .q(q_s));

   // Advance one edge; the model counts enabled edges since the last clear.
   task automatic step();
      @(posedge clk_36MHz);
      k_d = (!reset || !en_d) ? 0 : ((k_d < N_D) ? k_d + 1 : k_d);
      k_m = (!reset || !en_m) ? 0 : ((k_m < N_M) ? k_m + 1 : k_m);
      k_s = (!reset || !en_s) ? 0 : ((k_s < N_S) ? k_s + 1 : k_s);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en_d = 1'b1; en_m = 1'b1; en_s = 1'b1;
      repeat (3) step();
      tests_run++;
      if (q_d !== 1'b0) begin tests_failed++; $display("FAIL reset_q_d got=%b want=0", q_d); end
      tests_run++;
      if (q_m !== 1'b0) begin tests_failed++; $display("FAIL reset_q_m got=%b want=0", q_m); end
      tests_run++;
      if (q_s !== 1'b0) begin tests_failed++; $display("FAIL reset_q_s got=%b want=0", q_s); end
      $display("[TB] reset: q_d=%b q_m=%b q_s=%b", q_d, q_m, q_s);
   endtask

   task automatic test_timeout();
      logic q_before;
      q_before = 1'bx;
      reset = 1'b1;
      for (int e = 1; e <= N_D; e++) begin
         step();
         if (e == N_D - 1) q_before = q_d;
         tests_run++;
         if (q_d !== (k_d >= N_D)) begin
            tests_failed++;
            $display("FAIL timeout_track edge=%0d got=%b want=%b", e, q_d, (k_d >= N_D));
            break;
         end
      end
      tests_run++;
      if (q_before !== 1'b0) begin tests_failed++; $display("FAIL timeout_edge_N-1 got=%b want=0", q_before); end
      tests_run++;
      if (q_d !== 1'b1) begin tests_failed++; $display("FAIL timeout_edge_N got=%b want=1", q_d); end
      $display("[TB] timeout: q after edge %0d=%b, after edge %0d=%b", N_D - 1, q_before, N_D, q_d);
   endtask

   task automatic test_saturation();
      int held;
      held = 0;
      for (int e = 0; e < 2000; e++) begin
         step();
         tests_run++;
         if (q_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturation edge=%0d got=%b want=1", e, q_d);
            break;
         end
         held++;
      end
      $display("[TB] saturation: q held high for %0d extra edges", held);
   endtask

   task automatic test_clear();
      en_d = 1'b0;
      step();
      tests_run++;
      if (q_d !== 1'b0) begin tests_failed++; $display("FAIL clear_drop got=%b want=0", q_d); end
      en_d = 1'b1;
      for (int e = 1; e <= 500; e++) begin
         step();
         tests_run++;
         if (q_d !== (k_d >= N_D)) begin
            tests_failed++;
            $display("FAIL clear_restart edge=%0d got=%b want=%b", e, q_d, (k_d >= N_D));
            break;
         end
      end
      $display("[TB] clear: q after drop and 500 re-enabled edges=%b", q_d);
   endtask

   task automatic test_abort();
      en_m = 1'b0;
      step();
      en_m = 1'b1;
      repeat (100) step();
      en_m = 1'b0;
      step();
      tests_run++;
      if (q_m !== 1'b0) begin tests_failed++; $display("FAIL abort_drop got=%b want=0", q_m); end
      en_m = 1'b1;
      for (int e = 1; e <= N_M + 10; e++) begin
         step();
         tests_run++;
         if (q_m !== (e >= N_M)) begin
            tests_failed++;
            $display("FAIL abort_restart edge=%0d got=%b want=%b", e, q_m, (e >= N_M));
            break;
         end
      end
      $display("[TB] abort: q_m after re-enable + %0d edges=%b", N_M + 10, q_m);
   endtask

   task automatic test_reset_mid();
      en_m = 1'b0;
      step();
      en_m = 1'b1;
      repeat (120) step();
      reset = 1'b0;
      repeat (2) step();
      tests_run++;
      if (q_m !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_hold got=%b want=0", q_m); end
      reset = 1'b1;
      for (int e = 1; e <= N_M + 5; e++) begin
         step();
         tests_run++;
         if (q_m !== (e >= N_M)) begin
            tests_failed++;
            $display("FAIL reset_mid_restart edge=%0d got=%b want=%b", e, q_m, (e >= N_M));
            break;
         end
      end
      $display("[TB] reset_mid: q_m %0d edges after release=%b", N_M + 5, q_m);
   endtask

   task automatic test_small();
      en_s = 1'b0;
      step();
      en_s = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         step();
         tests_run++;
         if (q_s !== (e >= 6)) begin
            tests_failed++;
            $display("FAIL small edge=%0d got=%b want=%b", e, q_s, (e >= 6));
            break;
         end
      end
      $display("[TB] small: q_s after 16 edges=%b", q_s);
   endtask

   task automatic test_random();
      int rises_m;
      rises_m = 0;
      for (int e = 0; e < 10000; e++) begin
         if ($urandom_range(0, 199) == 0) en_m = ~en_m;
         if ($urandom_range(0, 7) == 0)   en_s = ~en_s;
         if ($urandom_range(0, 299) == 0) en_d = ~en_d;
         reset = ($urandom_range(0, 1499) != 0);
         step();
         if (k_m == N_M && q_m === 1'b1) rises_m++;
         tests_run++;
         if (q_d !== (k_d >= N_D) || q_m !== (k_m >= N_M) || q_s !== (k_s >= N_S)) begin
            tests_failed++;
            $display("FAIL random edge=%0d got d/m/s=%b%b%b want=%b%b%b", e, q_d, q_m, q_s,
                     (k_d >= N_D), (k_m >= N_M), (k_s >= N_S));
            break;
         end
      end
      $display("[TB] random: 10000 edges, medium timer high on %0d edges", rises_m);
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_saturation();
      test_clear();
      test_abort();
      test_reset_mid();
      test_small();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
